// File: rtl/m68k_uart.sv
// m68k_uart: memory-mapped 8N1 UART slave for the 68000 bus glue.
// Four-word register window (DATA, STATUS, two reserved) with a single-byte
// receive holding register and a single transmit shift register.
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line idle high, ready to accept a byte
//   TX_SHIFT | shifting {stop, data, start} out LSB first
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronized line
//   RX_START | waiting half a bit to confirm the start bit
//   RX_DATA  | sampling 8 data bits at bit centres
//   RX_STOP  | sampling the stop bit, then deliver or flag
module m68k_uart #(
    parameter int DIVISOR = 104
) (
    input  logic        clk12,
    input  logic        rst,
    input  logic        sel,
    input  logic        rw,
    input  logic [1:0]  reg_addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    input  logic        rx,
    output logic        tx
);

    localparam logic [15:0] DIV_LAST  = 16'(DIVISOR - 1);
    localparam logic [15:0] HALF_LAST = 16'(DIVISOR / 2 - 1);

    localparam logic [0:0] TX_IDLE  = 1'b0;
    localparam logic [0:0] TX_SHIFT = 1'b1;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic        sel_q;
    logic        acc;
    logic [15:0] rd_mux;

    logic [0:0]  tx_state;
    logic [9:0]  tx_sh;
    logic [3:0]  tx_bit;
    logic [15:0] tx_div;
    logic        tx_busy;
    logic        tx_accept;

    logic        rx_s1, rx_s2, rx_prev;
    logic [1:0]  rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        stop_tick;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_overrun;
    logic        framing_err;
    logic        pop;
    logic        w1c;

    logic        unused_wdata;
    assign unused_wdata = &{1'b0, wdata[15:8]};

    // Side effects fire only on the first cycle sel is seen high.
    assign acc       = sel & ~sel_q;
    assign pop       = acc & rw & (reg_addr == 2'd0);
    assign w1c       = acc & ~rw & (reg_addr == 2'd1);
    assign tx_busy   = (tx_state == TX_SHIFT);
    assign tx_accept = acc & ~rw & (reg_addr == 2'd0) & ~tx_busy;
    assign stop_tick = (rx_state == RX_STOP) && (rx_cnt == DIV_LAST);

    // Read data selection for the addressed register.
    always_comb begin
        rd_mux = 16'h0000;
        case (reg_addr)
            2'd0:    rd_mux = {8'h00, rx_data};
            2'd1:    rd_mux = {12'h000, framing_err, rx_overrun, tx_busy, rx_valid};
            default: rd_mux = 16'h0000;
        endcase
    end

    // Bus handshake: ack follows sel by one cycle, rdata captured once per access.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            sel_q <= 1'b0;
            ack   <= 1'b0;
            rdata <= 16'h0000;
        end else begin
            sel_q <= sel;
            ack   <= sel;
            if (acc)
                rdata <= rw ? rd_mux : 16'h0000;
            else if (!sel)
                rdata <= 16'h0000;
        end
    end

    // Transmit shifter; tx is registered so the start bit follows acceptance by a cycle.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_sh    <= 10'h3FF;
            tx_bit   <= 4'd0;
            tx_div   <= 16'd0;
            tx       <= 1'b1;
        end else begin
            tx <= (tx_state == TX_SHIFT) ? tx_sh[0] : 1'b1;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_accept) begin
                        tx_sh    <= {1'b1, wdata[7:0], 1'b0};
                        tx_bit   <= 4'd0;
                        tx_div   <= 16'd0;
                        tx_state <= TX_SHIFT;
                    end
                end
                default: begin
                    if (tx_div == DIV_LAST) begin
                        tx_div <= 16'd0;
                        if (tx_bit == 4'd9) begin
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_bit <= tx_bit + 4'd1;
                            tx_sh  <= {1'b1, tx_sh[9:1]};
                        end
                    end else begin
                        tx_div <= tx_div + 16'd1;
                    end
                end
            endcase
        end
    end

    // Two-flop synchronizer plus edge history for start detection.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Receive sequencer: half-bit start check, then centre sampling.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_sh    <= 8'h00;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= 16'd0;
                    if (rx_prev && !rx_s2)
                        rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= 16'd0;
                        rx_bit   <= 3'd0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt <= 16'd0;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        if (rx_bit == 3'd7)
                            rx_state <= RX_STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt   <= 16'd0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // Holding register and flags; a pop in the completion cycle frees the slot,
    // and a flag set beats a same-cycle write-one-to-clear.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            if (stop_tick && rx_s2 && (!rx_valid || pop)) begin
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
            end else if (pop) begin
                rx_valid <= 1'b0;
            end

            if (stop_tick && rx_s2 && rx_valid && !pop)
                rx_overrun <= 1'b1;
            else if (w1c && wdata[2])
                rx_overrun <= 1'b0;

            if (stop_tick && !rx_s2)
                framing_err <= 1'b1;
            else if (w1c && wdata[3])
                framing_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_m68k_uart.sv
// Directed bench for m68k_uart with an 8-cycle bit period.
module tb_m68k_uart;

    localparam int DIV = 8;

    localparam int OP_RX    = 0;
    localparam int OP_RXBAD = 1;
    localparam int OP_RD    = 2;
    localparam int OP_WR    = 3;
    localparam int OP_GLTCH = 4;

    logic        clk12 = 1'b0;
    logic        rst   = 1'b1;
    logic        sel   = 1'b0;
    logic        rw    = 1'b1;
    logic [1:0]  reg_addr = 2'd0;
    logic [15:0] wdata = 16'h0000;
    logic [15:0] rdata;
    logic        ack;
    logic        rx    = 1'b1;
    logic        tx;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          op;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
        string       name;
    } step_t;

    step_t steps[$];

    m68k_uart #(.DIVISOR(DIV)) dut (
        .clk12    (clk12),
        .rst      (rst),
        .sel      (sel),
        .rw       (rw),
        .reg_addr (reg_addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ack      (ack),
        .rx       (rx),
        .tx       (tx)
    );

    always #5 clk12 = ~clk12;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input int op, input logic [1:0] a, input logic [15:0] d,
                       input logic [15:0] e, input string nm);
        step_t s;
        s.op = op; s.addr = a; s.data = d; s.exp = e; s.name = nm;
        steps.push_back(s);
    endtask

    // Single-cycle bus access; entered and left one time unit after a rising edge.
    task automatic bus(input logic r, input logic [1:0] a, input logic [15:0] d,
                       output logic [15:0] rd);
        sel = 1'b1; rw = r; reg_addr = a; wdata = d;
        @(posedge clk12); #1;
        rd = rdata;
        sel = 1'b0; rw = 1'b1; wdata = 16'h0000;
        @(posedge clk12); #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (DIV) @(posedge clk12);
            #1;
        end
        rx = 1'b1;
        repeat (2 * DIV) @(posedge clk12);
        #1;
    endtask

    initial begin
        logic [15:0] rd;
        logic [9:0]  fr;
        int          lows;
        logic        ack_ok;
        logic        rd_ok;

        // Reset state
        repeat (3) @(posedge clk12);
        #1;
        chk("reset_tx", {15'h0, tx}, 16'h0001);
        chk("reset_ack", {15'h0, ack}, 16'h0000);
        chk("reset_rdata", rdata, 16'h0000);
        rst = 1'b0;
        repeat (2) @(posedge clk12);
        #1;

        add(OP_RD,    2'd1, 16'h0000, 16'h0000, "status_after_reset");
        add(OP_RX,    2'd0, 16'h003C, 16'h0000, "");
        add(OP_RD,    2'd1, 16'h0000, 16'h0001, "status_valid");
        add(OP_RD,    2'd0, 16'h0000, 16'h003C, "data_3c");
        add(OP_RD,    2'd1, 16'h0000, 16'h0000, "status_popped");
        add(OP_RX,    2'd0, 16'h0011, 16'h0000, "");
        add(OP_RX,    2'd0, 16'h0022, 16'h0000, "");
        add(OP_RD,    2'd1, 16'h0000, 16'h0005, "status_overrun");
        add(OP_RD,    2'd0, 16'h0000, 16'h0011, "data_keeps_old");
        add(OP_WR,    2'd1, 16'h0004, 16'h0000, "");
        add(OP_RD,    2'd1, 16'h0000, 16'h0000, "status_ovr_cleared");
        add(OP_RXBAD, 2'd0, 16'h0055, 16'h0000, "");
        add(OP_RD,    2'd1, 16'h0000, 16'h0008, "status_framing");
        add(OP_WR,    2'd1, 16'h0003, 16'h0000, "");
        add(OP_RD,    2'd1, 16'h0000, 16'h0008, "w1c_wrong_bits");
        add(OP_WR,    2'd1, 16'h0008, 16'h0000, "");
        add(OP_RD,    2'd1, 16'h0000, 16'h0000, "status_fe_cleared");
        add(OP_GLTCH, 2'd0, 16'h0000, 16'h0000, "");
        add(OP_RD,    2'd1, 16'h0000, 16'h0000, "status_after_glitch");
        add(OP_RD,    2'd0, 16'h0000, 16'h0011, "data_after_glitch");
        add(OP_WR,    2'd2, 16'h00FF, 16'h0000, "");
        add(OP_RD,    2'd2, 16'h0000, 16'h0000, "reg2_zero");
        add(OP_RD,    2'd3, 16'h0000, 16'h0000, "reg3_zero");
        add(OP_RX,    2'd0, 16'h007E, 16'h0000, "");
        add(OP_RX,    2'd0, 16'h0081, 16'h0000, "");
        add(OP_WR,    2'd1, 16'h0008, 16'h0000, "");
        add(OP_RD,    2'd1, 16'h0000, 16'h0005, "ovr_survives_fe_clr");
        add(OP_RD,    2'd0, 16'h0000, 16'h007E, "data_7e");
        add(OP_RD,    2'd1, 16'h0000, 16'h0004, "ovr_only");
        add(OP_WR,    2'd1, 16'h0004, 16'h0000, "");
        add(OP_RD,    2'd1, 16'h0000, 16'h0000, "all_clear");

        foreach (steps[k]) begin
            case (steps[k].op)
                OP_RX:    send_frame(steps[k].data[7:0], 1'b1);
                OP_RXBAD: send_frame(steps[k].data[7:0], 1'b0);
                OP_WR:    bus(1'b0, steps[k].addr, steps[k].data, rd);
                OP_GLTCH: begin
                    rx = 1'b0;
                    repeat (2) @(posedge clk12);
                    #1;
                    rx = 1'b1;
                    repeat (12 * DIV) @(posedge clk12);
                    #1;
                end
                default: begin
                    bus(1'b1, steps[k].addr, 16'h0000, rd);
                    chk(steps[k].name, rd, steps[k].exp);
                end
            endcase
        end

        // TX frame 0xA5: bus() returns one cycle after acceptance, start bit begins then
        fr = {1'b1, 8'hA5, 1'b0};
        bus(1'b0, 2'd0, 16'h00A5, rd);
        chk("write_rdata_zero", rd, 16'h0000);
        repeat (4) @(posedge clk12);
        #1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tx_bit%0d", i), {15'h0, tx}, {15'h0, fr[i]});
            if (i < 9) begin
                repeat (DIV) @(posedge clk12);
                #1;
            end
        end
        repeat (DIV) @(posedge clk12);
        #1;
        bus(1'b1, 2'd1, 16'h0000, rd);
        chk("tx_idle_after_frame", rd, 16'h0000);

        // Second write during a busy frame is dropped
        bus(1'b0, 2'd0, 16'h00A5, rd);
        bus(1'b1, 2'd1, 16'h0000, rd);
        chk("tx_busy_flag", rd, 16'h0002);
        bus(1'b0, 2'd0, 16'h0000, rd);
        repeat (10 * DIV) @(posedge clk12);
        #1;
        lows = 0;
        for (int i = 0; i < 12 * DIV; i++) begin
            if (tx !== 1'b1) lows++;
            @(posedge clk12);
            #1;
        end
        chk("no_second_frame", 16'(lows), 16'h0000);
        bus(1'b1, 2'd1, 16'h0000, rd);
        chk("tx_idle_after_drop", rd, 16'h0000);

        // Long DATA read: one pop even while a new byte lands during the access
        send_frame(8'h9A, 1'b1);
        ack_ok = 1'b1;
        rd_ok  = 1'b1;
        fork
            send_frame(8'h44, 1'b1);
            begin
                repeat (70) @(posedge clk12);
                #1;
                sel = 1'b1; rw = 1'b1; reg_addr = 2'd0;
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk12);
                    #1;
                    if (ack !== 1'b1) ack_ok = 1'b0;
                    if (rdata !== 16'h009A) rd_ok = 1'b0;
                end
                sel = 1'b0;
                @(posedge clk12);
                #1;
                chk("long_read_ack_falls", {15'h0, ack}, 16'h0000);
            end
        join
        chk("long_read_ack_high", {15'h0, ack_ok}, 16'h0001);
        chk("long_read_rdata_stable", {15'h0, rd_ok}, 16'h0001);
        bus(1'b1, 2'd1, 16'h0000, rd);
        chk("long_read_single_pop", rd, 16'h0001);
        bus(1'b1, 2'd0, 16'h0000, rd);
        chk("long_read_new_byte", rd, 16'h0044);

        // Reset in the middle of a TX frame
        bus(1'b0, 2'd0, 16'h0000, rd);
        repeat (20) @(posedge clk12);
        #1;
        chk("tx_low_mid_frame", {15'h0, tx}, 16'h0000);
        @(negedge clk12);
        rst = 1'b1;
        #1;
        chk("tx_async_reset", {15'h0, tx}, 16'h0001);
        @(posedge clk12);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk12);
        #1;
        bus(1'b1, 2'd1, 16'h0000, rd);
        chk("status_after_reset_mid_tx", rd, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
